// File: rtl/hex_scan_pkg.sv
// Shared definitions for the hex scan display controller: bus register
// addresses, CTRL bit positions, the CTRL register layout and its reset value.
// The blink bit only exists when HEX_SCAN_BLINK_EN is defined.
package hex_scan_pkg;

    localparam logic ADDR_VALUE = 1'b0;
    localparam logic ADDR_CTRL  = 1'b1;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_LZB_BIT   = 1;
    localparam int CTRL_BLINK_BIT = 2;

`ifdef HEX_SCAN_BLINK_EN
    localparam logic BLINK_BUILT = 1'b1;
`else
    localparam logic BLINK_BUILT = 1'b0;
`endif

    typedef struct packed {
        logic blink;
        logic lzb;
        logic enable;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{blink: 1'b0, lzb: 1'b0, enable: 1'b1};

    // Decode the low CTRL bits of a bus write; blink sticks at 0 when not built.
    function automatic ctrl_t ctrl_from_bits(input logic [2:0] b);
        ctrl_t c;
        c.enable = b[CTRL_EN_BIT];
        c.lzb    = b[CTRL_LZB_BIT];
        c.blink  = b[CTRL_BLINK_BIT] & BLINK_BUILT;
        return c;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Scan-rate prescaler: counts 0..DIV-1 while enabled and flags the last count
// as the scan tick. Disabling holds the count at 0 so a re-enable always
// waits one full period before the first tick.
module scan_prescaler #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Free-running modulo-DIV counter, cleared while the display is disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/hex_scan_ctrl.sv
// Memory-mapped hex display scanner. Holds a 32-bit VALUE and a CTRL word
// written over the peripheral bus, and walks one nibble per scan tick onto
// the shared decoder input with an active-low one-hot digit enable.
// Supports leading-zero blanking and a global enable.
// Optional build macro HEX_SCAN_BLINK_EN adds CTRL[2] blink with a phase
// counter that toggles every 256*NDIGITS scan ticks.
module hex_scan_ctrl
    import hex_scan_pkg::*;
#(
    parameter int NDIGITS = 8,
    parameter int DIV     = 50000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sel,
    input  logic               we,
    input  logic               addr,
    input  logic [3:0]         be,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ack,
    output logic [3:0]         nibble,
    output logic [NDIGITS-1:0] digit_an,
    output logic               blank
);

    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);
    // Only the nibbles that map to real digits take part in zero blanking.
    localparam logic [31:0] DISP_MASK = 32'hFFFF_FFFF >> (32 - 4 * NDIGITS);

    logic [31:0]      value_q;
    ctrl_t            ctrl_q;
    logic [IDX_W-1:0] idx_q;
    logic             tick;
    logic             suppress;
    logic             blink_off;
    logic [31:0]      rd_word;

    scan_prescaler #(.DIV(DIV)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (ctrl_q.enable),
        .tick    (tick)
    );

    // Digit i>0 is a leading zero when it and every higher shown nibble are 0.
    function automatic logic lead_zero(input logic [31:0] v, input logic [IDX_W-1:0] i);
        logic [31:0] upper;
        upper = (v & DISP_MASK) >> {i, 2'b00};
        return (i != '0) && (upper == 32'h0);
    endfunction

`ifdef HEX_SCAN_BLINK_EN
    localparam int PH_N = 256 * NDIGITS;
    localparam int PH_W = $clog2(PH_N);

    logic [PH_W-1:0] ph_cnt;
    logic            phase_on;

    // Blink phase advances with scan ticks so the scan itself never pauses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph_cnt   <= '0;
            phase_on <= 1'b1;
        end else if (tick) begin
            if (ph_cnt == PH_W'(PH_N - 1)) begin
                ph_cnt   <= '0;
                phase_on <= ~phase_on;
            end else begin
                ph_cnt <= ph_cnt + PH_W'(1);
            end
        end
    end

    assign blink_off = ctrl_q.blink && !phase_on;
`else
    assign blink_off = 1'b0;
`endif

    assign suppress = (ctrl_q.lzb && lead_zero(value_q, idx_q)) || blink_off;
    assign rd_word  = (addr == ADDR_CTRL) ? {29'h0, ctrl_q} : value_q;

    // Bus handshake: one-cycle ack after sel; read data captured pre-commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack   <= 1'b0;
            rdata <= 32'h0;
        end else begin
            ack   <= sel && !ack;
            rdata <= (sel && !ack && !we) ? rd_word : 32'h0;
        end
    end

    // Register writes commit at the end of the ack cycle, byte-masked.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= 32'h0;
            ctrl_q  <= CTRL_RST;
        end else if (ack && sel && we) begin
            if (addr == ADDR_VALUE) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) value_q[8*b +: 8] <= wdata[8*b +: 8];
                end
            end else if (be[0]) begin
                ctrl_q <= ctrl_from_bits(wdata[2:0]);
            end
        end
    end

    // Scan index names the digit the next tick will show.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q <= '0;
        end else if (!ctrl_q.enable) begin
            idx_q <= '0;
        end else if (tick) begin
            idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Display outputs move only on ticks, or go dark while disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nibble   <= 4'h0;
            digit_an <= '1;
            blank    <= 1'b1;
        end else if (!ctrl_q.enable) begin
            digit_an <= '1;
            blank    <= 1'b1;
        end else if (tick) begin
            nibble <= 4'(value_q >> {idx_q, 2'b00});
            if (suppress) begin
                digit_an <= '1;
                blank    <= 1'b1;
            end else begin
                digit_an <= ~(NDIGITS'(1) << idx_q);
                blank    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl (NDIGITS=8, DIV=4). A reference
// model tracks elapsed enabled cycles and derives the shown digit from them
// arithmetically; every clock the DUT outputs are compared with it.
module tb_hex_scan_ctrl;

    localparam int NDIGITS = 8;
    localparam int DIV     = 4;
`ifdef HEX_SCAN_BLINK_EN
    localparam logic [2:0] CTRL_MASK = 3'b111;
`else
    localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sel, we, addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic [3:0]  nibble;
    logic [7:0]  digit_an;
    logic        blank;

    hex_scan_ctrl #(.NDIGITS(NDIGITS), .DIV(DIV)) dut (
        .clk(clk), .reset_n(reset_n), .sel(sel), .we(we), .addr(addr),
        .be(be), .wdata(wdata), .rdata(rdata), .ack(ack),
        .nibble(nibble), .digit_an(digit_an), .blank(blank)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rel_edge = 0;

    // Reference model state
    logic [31:0] m_val, m_rdata;
    logic [2:0]  m_ctrl;
    logic        m_ack;
    logic [3:0]  m_nib;
    logic [7:0]  m_an;
    logic        m_blank;
    int          m_el;
    int          m_ticks;

    typedef struct {
        logic        w;
        logic        a;
        logic [3:0]  b;
        logic [31:0] d;
        logic [31:0] exp;
    } bus_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_val = 32'h0; m_ctrl = 3'b001; m_ack = 1'b0; m_rdata = 32'h0;
        m_nib = 4'h0; m_an = 8'hFF; m_blank = 1'b1; m_el = 0; m_ticks = 0;
    endtask

    // Effect of one rising edge on the model, using pre-edge register state.
    task automatic edge_model();
        logic [31:0] ov;
        logic [2:0]  oc;
        logic        oa, supp;
        int          d;
        if (!reset_n) begin
            model_reset();
        end else begin
            ov = m_val; oc = m_ctrl; oa = m_ack;
            if (oc[0]) begin
                if (m_el % DIV == DIV - 1) begin
                    d = (m_el / DIV) % NDIGITS;
                    supp = oc[1] && (d != 0) && ((ov >> (4 * d)) == 32'h0);
                    if (oc[2] && ((m_ticks / (256 * NDIGITS)) % 2 == 1)) supp = 1'b1;
                    m_ticks++;
                    m_nib   = 4'(ov >> (4 * d));
                    m_an    = supp ? 8'hFF : ~(8'h01 << d);
                    m_blank = supp;
                end
                m_el++;
            end else begin
                m_el = 0; m_an = 8'hFF; m_blank = 1'b1;
            end
            m_rdata = 32'h0;
            if (sel && !oa && !we) m_rdata = addr ? {29'h0, oc} : ov;
            if (oa && sel && we) begin
                if (!addr) begin
                    for (int b = 0; b < 4; b++) if (be[b]) m_val[8*b +: 8] = wdata[8*b +: 8];
                end else if (be[0]) begin
                    m_ctrl = wdata[2:0] & CTRL_MASK;
                end
            end
            m_ack = sel && !oa;
        end
    endtask

    task automatic check_now(input string name);
        chk(name, {18'h0, nibble, digit_an, blank, ack, rdata},
                  {18'h0, m_nib, m_an, m_blank, m_ack, m_rdata});
    endtask

    task automatic step();
        @(posedge clk);
        edge_model();
        rel_edge++;
        #1;
        check_now("cycle");
    endtask

    task automatic bus(input logic w, input logic a, input logic [3:0] b,
                       input logic [31:0] d, output logic [31:0] rd);
        sel = 1'b1; we = w; addr = a; be = b; wdata = d;
        step();
        rd = rdata;
        chk("ack_rise", {63'h0, ack}, 64'h1);
        step();
        chk("ack_fall", {63'h0, ack}, 64'h0);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("reset_vals", {18'h0, nibble, digit_an, blank, ack, rdata},
                          {18'h0, 4'h0, 8'hFF, 1'b1, 1'b0, 32'h0});
        step(); step();
        reset_n = 1'b1;
        rel_edge = 0;
    endtask

    // Flush one full scan, lock onto digit 0, then check eight ticks.
    task automatic scan_check(input string name, input logic [31:0] nibs, input logic [7:0] smask);
        int waited = 0;
        logic [7:0] exp_an;
        for (int i = 0; i < DIV * NDIGITS; i++) step();
        while (digit_an !== 8'hFE && waited < 64) begin
            step();
            waited++;
        end
        if (waited >= 64) begin
            chk({name, "_sync"}, {56'h0, digit_an}, 64'hFE);
        end else begin
            for (int k = 0; k < NDIGITS; k++) begin
                exp_an = smask[k] ? 8'hFF : ~(8'h01 << k);
                chk($sformatf("%s_d%0d", name, k), {51'h0, nibble, digit_an, blank},
                    {51'h0, nibs[4*k +: 4], exp_an, smask[k]});
                for (int s = 0; s < DIV; s++) step();
            end
        end
    endtask

    bus_vec_t    tbl[13];
    logic [31:0] rd;
    logic [31:0] ctrl_all;

    initial begin
        reset_n = 1'b1; sel = 1'b0; we = 1'b0; addr = 1'b0; be = 4'h0; wdata = 32'h0;
        model_reset();
        #3;
        do_reset();

        // Reset register contents
        bus(1'b0, 1'b1, 4'hF, 32'h0, rd); chk("rst_ctrl", {32'h0, rd}, 64'h1);
        bus(1'b0, 1'b0, 4'hF, 32'h0, rd); chk("rst_value", {32'h0, rd}, 64'h0);

        // Basic scan order
        bus(1'b1, 1'b0, 4'hF, 32'h1234ABCD, rd);
        scan_check("scan", 32'h1234ABCD, 8'h00);

        // Register access table
        ctrl_all = (CTRL_MASK == 3'b111) ? 32'h7 : 32'h3;
        tbl[0]  = '{1'b1, 1'b0, 4'hF, 32'h00000000, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 4'h2, 32'hFFFFFFFF, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 4'hF, 32'h0,        32'h0000FF00};
        tbl[3]  = '{1'b1, 1'b0, 4'h9, 32'hA5A5A5A5, 32'h0};
        tbl[4]  = '{1'b0, 1'b0, 4'h0, 32'h0,        32'hA500FFA5};
        tbl[5]  = '{1'b1, 1'b1, 4'h1, 32'hFFFFFFFF, 32'h0};
        tbl[6]  = '{1'b0, 1'b1, 4'hF, 32'h0,        ctrl_all};
        tbl[7]  = '{1'b1, 1'b1, 4'h0, 32'h00000000, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 4'hF, 32'h0,        ctrl_all};
        tbl[9]  = '{1'b1, 1'b1, 4'hE, 32'h00000000, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 4'hF, 32'h0,        ctrl_all};
        tbl[11] = '{1'b1, 1'b1, 4'hF, 32'h00000001, 32'h0};
        tbl[12] = '{1'b0, 1'b1, 4'hF, 32'h0,        32'h1};
        for (int i = 0; i < 13; i++) begin
            bus(tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].d, rd);
            if (!tbl[i].w) chk($sformatf("table%0d", i), {32'h0, rd}, {32'h0, tbl[i].exp});
        end

        // Leading-zero blanking
        bus(1'b1, 1'b0, 4'hF, 32'h00000050, rd);
        bus(1'b1, 1'b1, 4'hF, 32'h00000003, rd);
        scan_check("lzb50", 32'h00000050, 8'hFC);
        bus(1'b1, 1'b0, 4'hF, 32'h00000000, rd);
        scan_check("lzb0", 32'h00000000, 8'hFE);

        // Disable mid-scan, then re-enable
        bus(1'b1, 1'b0, 4'hF, 32'h00000009, rd);
        for (int i = 0; i < 5; i++) step();
        bus(1'b1, 1'b1, 4'hF, 32'h00000000, rd);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("dis_hold", {55'h0, digit_an, blank}, {55'h0, 8'hFF, 1'b1});
        end
        bus(1'b1, 1'b1, 4'hF, 32'h00000001, rd);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reen_wait", {55'h0, digit_an, blank}, {55'h0, 8'hFF, 1'b1});
        end
        step();
        chk("reen_first", {51'h0, nibble, digit_an, blank}, {51'h0, 4'h9, 8'hFE, 1'b0});

        // Randomized traffic against the model
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int s = 0; s < int'($urandom_range(1, 8)); s++) step();
            end else begin
                logic        ra;
                logic [31:0] rw;
                ra = 1'($urandom_range(0, 1));
                rw = $urandom;
                if (ra && $urandom_range(0, 9) != 0) rw[0] = 1'b1;
                bus(1'($urandom_range(0, 1)), ra, 4'($urandom_range(0, 15)), rw, rd);
            end
        end

        // Reset during a pending write
        sel = 1'b1; we = 1'b1; addr = 1'b0; be = 4'hF; wdata = 32'hDEADBEEF;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst", {18'h0, nibble, digit_an, blank, ack, rdata},
                         {18'h0, 4'h0, 8'hFF, 1'b1, 1'b0, 32'h0});
        step(); step();
        sel = 1'b0; we = 1'b0;
        reset_n = 1'b1;
        rel_edge = 0;
        bus(1'b0, 1'b0, 4'hF, 32'h0, rd); chk("drop_value", {32'h0, rd}, 64'h0);
        bus(1'b0, 1'b1, 4'hF, 32'h0, rd); chk("drop_ctrl", {32'h0, rd}, 64'h1);

`ifdef HEX_SCAN_BLINK_EN
        // Blink phases: ticks land on edges 4t+4 after reset release
        do_reset();
        bus(1'b1, 1'b0, 4'hF, 32'h87654321, rd);
        bus(1'b1, 1'b1, 4'hF, 32'h00000005, rd);
        while (rel_edge < 8192) step();
        chk("blink_on_end", {51'h0, nibble, digit_an, blank}, {51'h0, 4'h8, 8'h7F, 1'b0});
        while (rel_edge < 8196) step();
        chk("blink_off_start", {55'h0, digit_an, blank}, {55'h0, 8'hFF, 1'b1});
        while (rel_edge < 16384) step();
        chk("blink_off_end", {55'h0, digit_an, blank}, {55'h0, 8'hFF, 1'b1});
        while (rel_edge < 16388) step();
        chk("blink_on_again", {51'h0, nibble, digit_an, blank}, {51'h0, 4'h1, 8'hFE, 1'b0});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
